// File: rtl/proc_pkg.sv
// Shared definitions for the pipelined processor: opcode constants, the NOP
// encoding, the default address width and the fetch issue-FSM state type.
package proc_pkg;

   localparam int ADDR_W_DEF = 8;

   localparam logic [3:0] OP_LOAD     = 4'd0;
   localparam logic [3:0] OP_STOP     = 4'd1;
   localparam logic [3:0] OP_STORE    = 4'd2;
   localparam logic [3:0] OP_SHIFT    = 4'd3;
   localparam logic [3:0] OP_ADD      = 4'd4;
   localparam logic [3:0] OP_BZ       = 4'd5;
   localparam logic [3:0] OP_SUBTRACT = 4'd6;
   localparam logic [3:0] OP_ORI      = 4'd7;
   localparam logic [3:0] OP_NAND     = 4'd8;
   localparam logic [3:0] OP_BNZ      = 4'd9;
   localparam logic [3:0] OP_NOP      = 4'd10;
   localparam logic [3:0] OP_BPZ      = 4'd13;

   localparam logic [7:0] NOP_INSTR = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   function automatic logic is_stop(input logic [7:0] instr);
      return instr[3:0] == OP_STOP;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instruction, address} pairs. DEPTH must be a power of two.
// A pop and a push in the same cycle are both honoured, including when full;
// flush empties the FIFO and overrides any push or pop in that cycle.
module fetch_fifo #(
   parameter int  DEPTH  = 2,
   parameter int  ADDR_W = 8,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [7:0]        push_instr_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   output logic [7:0]        head_instr_o,
   output logic [ADDR_W-1:0] head_addr_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [7:0]        instr_mem [DEPTH];
   logic [ADDR_W-1:0] addr_mem  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push, do_pop;

   assign empty_o      = (count_q == '0);
   assign full_o       = (count_q == CNT_W'(DEPTH));
   assign count_o      = count_q;
   assign do_pop       = pop_i && !empty_o;
   assign do_push      = push_i && (!full_o || do_pop);
   assign head_instr_o = instr_mem[rd_ptr_q];
   assign head_addr_o  = addr_mem[rd_ptr_q];

   // Pointer and occupancy bookkeeping; flush wins over push and pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Entry storage write.
   // NOTE: the storage array has no reset; pointers and count alone say which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         instr_mem[wr_ptr_q] <= push_instr_i;
         addr_mem[wr_ptr_q]  <= push_addr_i;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time requests to
// instruction memory, buffers responses in a prefetch FIFO and drives IR1/PC1.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_stage
   import proc_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en_fetch,
   input  logic              ir1_load,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [7:0]        imem_data,
   output logic [7:0]        ir1,
   output logic [ADDR_W-1:0] pc1,
   output logic              ir1_valid,
   output logic              halted
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]       stat_fetched,
   output logic [15:0]       stat_bubbles
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q, imem_addr_q, pc1_q;
   logic              outstanding_q, epoch_q, req_epoch_q, imem_req_q, ir1_valid_q;
   logic [7:0]        ir1_q;

   logic              resp_fire, fifo_push, fifo_pop, load_req, stop_in_ir1, issue;
   logic              fifo_full, fifo_empty;
   logic [7:0]        head_instr;
   logic [ADDR_W-1:0] head_addr;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    slots_used;

   assign halted      = (state_q == ST_HALT);
   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign ir1         = ir1_q;
   assign pc1         = pc1_q;
   assign ir1_valid   = ir1_valid_q;

   // A response only counts against a request we still consider outstanding.
   assign resp_fire   = imem_valid && outstanding_q;
   assign fifo_push   = resp_fire && (req_epoch_q == epoch_q) && !branch;
   // IR1 keeps a stop instruction until a branch replaces it.
   assign stop_in_ir1 = ir1_valid_q && is_stop(ir1_q);
   assign load_req    = en_fetch && ir1_load && !halted && !stop_in_ir1 && !branch;
   assign fifo_pop    = load_req && !fifo_empty;
   assign slots_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding_q};
   assign issue       = !branch && en_fetch && !halted && !fifo_full &&
                        (!outstanding_q || resp_fire) &&
                        (slots_used < (CNT_W+1)'(DEPTH));

   fetch_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk_i        (clock),
      .rst_ni       (reset),
      .push_i       (fifo_push),
      .pop_i        (fifo_pop),
      .flush_i      (branch),
      .push_instr_i (imem_data),
      .push_addr_i  (imem_addr_q),
      .head_instr_o (head_instr),
      .head_addr_o  (head_addr),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .count_o      (fifo_count)
   );

   // Issue FSM: PC, outstanding-request tracking, epoch and registered request outputs.
   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         outstanding_q <= 1'b0;
         epoch_q       <= 1'b0;
         req_epoch_q   <= 1'b0;
         imem_req_q    <= 1'b0;
         imem_addr_q   <= '0;
      end else begin
         imem_req_q <= issue;
         if (issue) begin
            imem_addr_q   <= pc_q;
            pc_q          <= pc_q + ADDR_W'(1);
            req_epoch_q   <= epoch_q;
            outstanding_q <= 1'b1;
         end else if (resp_fire) begin
            outstanding_q <= 1'b0;
         end

         if (branch) begin
            pc_q    <= branch_target;
            epoch_q <= ~epoch_q;
            // Tag the in-flight request with the old epoch so it can never match
            // again, even when branch stays high and the epoch keeps toggling.
            req_epoch_q <= epoch_q;
            state_q <= (outstanding_q && !resp_fire) ? ST_WAIT : ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (stop_in_ir1) state_q <= ST_HALT;
                  else if (issue)  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (stop_in_ir1)    state_q <= ST_HALT;
                  else if (resp_fire) state_q <= issue ? ST_WAIT : ST_IDLE;
               end
               ST_HALT: state_q <= ST_HALT;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // IR1/PC1 register: branch bubble, load from FIFO head, empty-FIFO bubble, or hold.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ir1_q       <= NOP_INSTR;
         pc1_q       <= '0;
         ir1_valid_q <= 1'b0;
      end else if (branch) begin
         ir1_q       <= NOP_INSTR;
         ir1_valid_q <= 1'b0;
      end else if (load_req) begin
         if (!fifo_empty) begin
            ir1_q       <= head_instr;
            pc1_q       <= head_addr;
            ir1_valid_q <= 1'b1;
         end else begin
            ir1_q       <= NOP_INSTR;
            ir1_valid_q <= 1'b0;
         end
      end
   end

`ifdef FETCH_STATS_EN
   // Saturating fetch and bubble counters, frozen while halted.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_fetched <= '0;
         stat_bubbles <= '0;
      end else if (!halted) begin
         if (fifo_push && (stat_fetched != 16'hFFFF))
            stat_fetched <= stat_fetched + 16'd1;
         if (en_fetch && ir1_load && fifo_empty && (stat_bubbles != 16'hFFFF))
            stat_bubbles <= stat_bubbles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A transaction-level model (queue of
// fetched addresses, one pending memory request) predicts IR1/PC1/halted and
// the legal request stream; scenario tasks add targeted checks.
module tb_fetch_stage;

   localparam int         DEPTH = 2;
   localparam logic [7:0] NOP   = 8'h0A;

   logic       clock, reset, en_fetch, ir1_load, branch, imem_valid;
   logic [7:0] branch_target, imem_data;
   logic       imem_req, ir1_valid, halted;
   logic [7:0] imem_addr, ir1, pc1;
`ifdef FETCH_STATS_EN
   logic [15:0] stat_fetched, stat_bubbles;
`endif

   fetch_stage #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
      .clock         (clock),
      .reset         (reset),
      .en_fetch      (en_fetch),
      .ir1_load      (ir1_load),
      .branch        (branch),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_valid    (imem_valid),
      .imem_data     (imem_data),
      .ir1           (ir1),
      .pc1           (pc1),
      .ir1_valid     (ir1_valid),
      .halted        (halted)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched  (stat_fetched),
      .stat_bubbles  (stat_bubbles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Memory image and reference model state
   logic [7:0] mem [256];
   logic [7:0] q [$];
   logic [7:0] exp_ir1, exp_pc1, exp_issue_pc, pend_addr;
   logic       exp_v, halted_m, pend_v, pend_stale, force_valid, last_req;
   int         pend_due, lat_min, lat_max, m_fetched, m_bubbles;
   logic [7:0] req_log [$];
   logic [7:0] ld_ir [$];
   logic [7:0] ld_pc [$];

   task automatic fill_mem_random();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if (b[3:0] == 4'd1) b[3:0] = 4'd2;
         mem[i] = b;
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_ir1 = NOP; exp_pc1 = 8'h00; exp_v = 1'b0; halted_m = 1'b0;
      pend_v = 1'b0; pend_stale = 1'b0; exp_issue_pc = 8'h00;
      m_fetched = 0; m_bubbles = 0; last_req = 1'b0;
      req_log.delete(); ld_ir.delete(); ld_pc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0; en_fetch = 1'b0; ir1_load = 1'b0; branch = 1'b0;
      branch_target = 8'h00; imem_valid = 1'b0; imem_data = 8'h00; force_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic check_reset_vals(input string name);
      tests++; if (ir1 !== NOP)       begin fails++; $display("FAIL %s ir1: got %h want %h", name, ir1, NOP); end
      tests++; if (pc1 !== 8'h00)     begin fails++; $display("FAIL %s pc1: got %h want 00", name, pc1); end
      tests++; if (ir1_valid !== 1'b0) begin fails++; $display("FAIL %s ir1_valid: got %b want 0", name, ir1_valid); end
      tests++; if (halted !== 1'b0)   begin fails++; $display("FAIL %s halted: got %b want 0", name, halted); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL %s imem_req: got %b want 0", name, imem_req); end
   endtask

   // One clock cycle: drive the memory response, advance, update the model, compare.
   task automatic step();
      logic       resp, s_en, s_ld, s_br, halted_pre, stop_now;
      logic [7:0] s_tgt, a;
      resp = 1'b0;
      if (force_valid) begin
         imem_valid = 1'b1; imem_data = 8'h77;
      end else if (pend_v && cyc >= pend_due) begin
         imem_valid = 1'b1; imem_data = mem[pend_addr]; resp = 1'b1;
      end else begin
         imem_valid = 1'b0; imem_data = 8'h00;
      end
      s_en = en_fetch; s_ld = ir1_load; s_br = branch; s_tgt = branch_target;
      @(posedge clock);
      #1;
      cyc++;
      halted_pre = halted_m;
      stop_now   = exp_v && (exp_ir1[3:0] == 4'd1);
      if (s_en && s_ld && !halted_pre && q.size() == 0) m_bubbles++;
      if (resp && !pend_stale && !s_br && !halted_pre) m_fetched++;
      if (s_br) begin
         q.delete();
         exp_ir1 = NOP; exp_v = 1'b0; halted_m = 1'b0; exp_issue_pc = s_tgt;
         if (pend_v && !resp) pend_stale = 1'b1;
      end else begin
         if (s_en && s_ld && !halted_pre && !stop_now) begin
            if (q.size() > 0) begin
               a = q.pop_front();
               exp_ir1 = mem[a]; exp_pc1 = a; exp_v = 1'b1;
               ld_ir.push_back(ir1); ld_pc.push_back(pc1);
            end else begin
               exp_ir1 = NOP; exp_v = 1'b0;
            end
         end
         if (resp && !pend_stale) q.push_back(pend_addr);
         if (stop_now) halted_m = 1'b1;
      end
      if (resp) begin pend_v = 1'b0; pend_stale = 1'b0; end
      last_req = 1'b0;
      if (imem_req === 1'b1) begin
         last_req = 1'b1;
         req_log.push_back(imem_addr);
         tests++;
         if (imem_addr !== exp_issue_pc) begin
            fails++; $display("FAIL req_addr cyc %0d: got %h want %h", cyc, imem_addr, exp_issue_pc);
         end
         tests++;
         if (pend_v || s_br || halted_pre || q.size() >= DEPTH) begin
            fails++;
            $display("FAIL req_legal cyc %0d: got req with pend=%b br=%b halted=%b fifo=%0d want no req",
                     cyc, pend_v, s_br, halted_pre, q.size());
         end
         pend_v = 1'b1; pend_addr = exp_issue_pc; pend_stale = 1'b0;
         pend_due = cyc + int'($urandom_range(lat_max, lat_min));
         exp_issue_pc = exp_issue_pc + 8'd1;
      end
      tests++;
      if (ir1_valid !== exp_v || ir1 !== exp_ir1 || (exp_v && pc1 !== exp_pc1)) begin
         fails++;
         $display("FAIL ir1 cyc %0d: got ir1=%h v=%b pc1=%h want ir1=%h v=%b pc1=%h",
                  cyc, ir1, ir1_valid, pc1, exp_ir1, exp_v, exp_pc1);
      end
      tests++;
      if (halted !== halted_m) begin
         fails++; $display("FAIL halted cyc %0d: got %b want %b", cyc, halted, halted_m);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++; fails++; $display("FAIL %s: got timeout want event", name);
   endtask

   task automatic test_reset();
      do_reset();
      check_reset_vals("reset");
   endtask

   task automatic test_sequence();
      int n;
      fill_mem_random();
      mem[0] = 8'h04; mem[1] = 8'h06; mem[2] = 8'h08; mem[3] = 8'h0A;
      lat_min = 1; lat_max = 1;
      do_reset();
      en_fetch = 1'b1; ir1_load = 1'b1;
      n = 0;
      while (ld_ir.size() < 4 && n < 40) begin step(); n++; end
      if (ld_ir.size() < 4) timeout_fail("seq_loads");
      else for (int i = 0; i < 4; i++) begin
         tests++;
         if (ld_ir[i] !== mem[i] || ld_pc[i] !== 8'(i)) begin
            fails++; $display("FAIL seq_load%0d: got %h@%h want %h@%h", i, ld_ir[i], ld_pc[i], mem[i], 8'(i));
         end
      end
   endtask

   task automatic test_hold();
      int n;
      fill_mem_random();
      mem[0] = 8'h04; mem[1] = 8'h06; mem[2] = 8'h08; mem[3] = 8'h0A;
      lat_min = 1; lat_max = 1;
      do_reset();
      en_fetch = 1'b1; ir1_load = 1'b1;
      n = 0;
      while (!(ir1 === 8'h06 && ir1_valid === 1'b1) && n < 40) begin step(); n++; end
      if (n >= 40) timeout_fail("hold_wait06");
      ir1_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (ir1 !== 8'h06 || pc1 !== 8'h01 || ir1_valid !== 1'b1) begin
            fails++; $display("FAIL hold%0d: got %h@%h v=%b want 06@01 v=1", i, ir1, pc1, ir1_valid);
         end
      end
      tests++;
      if (q.size() != DEPTH) begin fails++; $display("FAIL hold_fill: got %0d want %0d", q.size(), DEPTH); end
      step();
      tests++;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_noreq: got %b want 0", imem_req); end
      ir1_load = 1'b1;
      n = 0;
      while (!last_req && n < 6) begin step(); n++; end
      if (!last_req) timeout_fail("hold_resume_req");
   endtask

   task automatic test_branch();
      int n;
      fill_mem_random();
      mem[8'h20] = 8'h44;
      lat_min = 3; lat_max = 3;
      do_reset();
      en_fetch = 1'b1; ir1_load = 1'b1;
      n = 0;
      while (!last_req && n < 20) begin step(); n++; end
      step();
      branch = 1'b1; branch_target = 8'h20;
      step();
      branch = 1'b0;
      tests++;
      if (ir1 !== NOP || ir1_valid !== 1'b0) begin
         fails++; $display("FAIL br_bubble: got %h v=%b want 0a v=0", ir1, ir1_valid);
      end
      req_log.delete(); ld_ir.delete(); ld_pc.delete();
      n = 0;
      while (ld_ir.size() == 0 && n < 30) begin step(); n++; end
      if (req_log.size() == 0 || ld_ir.size() == 0) timeout_fail("br_first");
      else begin
         tests++;
         if (req_log[0] !== 8'h20) begin fails++; $display("FAIL br_addr: got %h want 20", req_log[0]); end
         tests++;
         if (ld_ir[0] !== 8'h44 || ld_pc[0] !== 8'h20) begin
            fails++; $display("FAIL br_load: got %h@%h want 44@20", ld_ir[0], ld_pc[0]);
         end
      end
      // Branch held over several cycles: last target wins
      for (int i = 0; i < 3; i++) begin
         branch = 1'b1; branch_target = 8'h30 + 8'(i);
         step();
      end
      branch = 1'b0;
      req_log.delete();
      n = 0;
      while (req_log.size() == 0 && n < 20) begin step(); n++; end
      if (req_log.size() == 0) timeout_fail("br_held");
      else begin
         tests++;
         if (req_log[0] !== 8'h32) begin fails++; $display("FAIL br_held: got %h want 32", req_log[0]); end
      end
   endtask

   task automatic test_stop();
      int n, reqs;
      fill_mem_random();
      mem[0] = 8'h04; mem[1] = 8'h06; mem[2] = 8'h08; mem[3] = 8'h0A; mem[4] = 8'h01;
      lat_min = 1; lat_max = 1;
      do_reset();
      en_fetch = 1'b1; ir1_load = 1'b1;
      n = 0;
      while (halted !== 1'b1 && n < 60) begin step(); n++; end
      if (n >= 60) timeout_fail("stop_halt");
      tests++;
      if (ir1 !== 8'h01 || pc1 !== 8'h04) begin fails++; $display("FAIL stop_ir1: got %h@%h want 01@04", ir1, pc1); end
      reqs = 0;
      for (int i = 0; i < 8; i++) begin step(); if (last_req) reqs++; end
      tests++;
      if (reqs != 0) begin fails++; $display("FAIL stop_noreq: got %0d want 0", reqs); end
      branch = 1'b1; branch_target = 8'h10;
      step();
      branch = 1'b0;
      tests++;
      if (halted !== 1'b0) begin fails++; $display("FAIL stop_clear: got %b want 0", halted); end
      req_log.delete();
      n = 0;
      while (req_log.size() == 0 && n < 10) begin step(); n++; end
      if (req_log.size() == 0) timeout_fail("stop_resume");
      else begin
         tests++;
         if (req_log[0] !== 8'h10) begin fails++; $display("FAIL stop_resume: got %h want 10", req_log[0]); end
      end
   endtask

   task automatic test_wrap_and_reset();
      int n;
      fill_mem_random();
      mem[0] = 8'h24;
      lat_min = 3; lat_max = 3;
      do_reset();
      en_fetch = 1'b1; ir1_load = 1'b1;
      branch = 1'b1; branch_target = 8'hFF;
      step();
      branch = 1'b0;
      req_log.delete();
      n = 0;
      while (req_log.size() < 2 && n < 30) begin step(); n++; end
      if (req_log.size() < 2) timeout_fail("wrap");
      else begin
         tests++;
         if (req_log[0] !== 8'hFF || req_log[1] !== 8'h00) begin
            fails++; $display("FAIL wrap: got %h,%h want ff,00", req_log[0], req_log[1]);
         end
      end
      n = 0;
      while (!last_req && n < 20) begin step(); n++; end
      step();
      // Asynchronous reset while a request is in flight
      reset = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      @(posedge clock);
      #1 reset = 1'b1;
      model_reset();
      en_fetch = 1'b0; ir1_load = 1'b0; force_valid = 1'b1;
      step(); step();
      force_valid = 1'b0;
      en_fetch = 1'b1; ir1_load = 1'b1;
      n = 0;
      while (ld_ir.size() == 0 && n < 30) begin step(); n++; end
      if (ld_ir.size() == 0) timeout_fail("post_reset_load");
      else begin
         tests++;
         if (ld_ir[0] !== 8'h24 || ld_pc[0] !== 8'h00) begin
            fails++; $display("FAIL post_reset_load: got %h@%h want 24@00", ld_ir[0], ld_pc[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int reqs;
      fill_mem_random();
      lat_min = 1; lat_max = 1;
      do_reset();
      en_fetch = 1'b1; ir1_load = 1'b1;
      repeat (6) step();
      reqs = 0;
      for (int i = 0; i < 40; i++) begin step(); if (last_req) reqs++; end
      tests++;
      if (reqs < 19 || reqs > 21) begin fails++; $display("FAIL b2b_rate: got %0d want 20 in 40 cycles", reqs); end
   endtask

   task automatic test_random();
      fill_mem_random();
      lat_min = 1; lat_max = 3;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         en_fetch      = ($urandom_range(7, 0) != 0);
         ir1_load      = ($urandom_range(3, 0) != 0);
         branch        = ($urandom_range(39, 0) == 0);
         branch_target = 8'($urandom);
         step();
      end
      branch = 1'b0;
   endtask

`ifdef FETCH_STATS_EN
   task automatic test_stats();
      fill_mem_random();
      lat_min = 1; lat_max = 1;
      do_reset();
      en_fetch = 1'b1; ir1_load = 1'b1;
      while (m_fetched < 5) step();
      ir1_load = 1'b0;
      repeat (2) step();
      tests++;
      if (stat_fetched !== 16'(m_fetched)) begin
         fails++; $display("FAIL stat_fetched: got %0d want %0d", stat_fetched, m_fetched);
      end
      tests++;
      if (stat_bubbles !== 16'(m_bubbles)) begin
         fails++; $display("FAIL stat_bubbles: got %0d want %0d", stat_bubbles, m_bubbles);
      end
   endtask
`endif

   initial begin
      reset = 1'b0; en_fetch = 1'b0; ir1_load = 1'b0; branch = 1'b0;
      branch_target = 8'h00; imem_valid = 1'b0; imem_data = 8'h00; force_valid = 1'b0;
      lat_min = 1; lat_max = 1;
      model_reset();
      test_reset();
      test_sequence();
      test_hold();
      test_branch();
      test_stop();
      test_wrap_and_reset();
      test_back_to_back();
      test_random();
`ifdef FETCH_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
